// File: rtl/occupancy_counter_pkg.sv
// Shared widths and defaults for the occupancy counter and its input conditioning.
package occ_pkg;

    localparam int NOW_W          = 6;
    localparam int SUM_W          = 10;
    localparam int SUM_MAX_DEF    = 999;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int DEB_W          = $clog2(DEB_CYCLES_DEF);

    // Counter width for a given debounce length, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/occupancy_counter_if.sv
// Button inputs, clear strobe and display-facing outputs of the occupancy counter.
interface occupancy_counter_if;
    import occ_pkg::*;

    logic             btn_in;
    logic             btn_out;
    logic             sum_clr;
    logic [NOW_W-1:0] now_num;
    logic [SUM_W-1:0] sum_num;
    logic             full_led;
    logic             reject;

    modport master (
        output btn_in, btn_out, sum_clr,
        input  now_num, sum_num, full_led, reject
    );

    modport slave (
        input  btn_in, btn_out, sum_clr,
        output now_num, sum_num, full_led, reject
    );

endinterface

// File: rtl/occupancy_counter_key_debounce.sv
// Synchronise, debounce and edge-detect one raw button; pulse is one cycle per accepted press.
// Pulse appears DEB_CYCLES+2 clocks after a clean edge; releases produce no pulse.
module key_debounce
    import occ_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int            CW   = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            pulse  <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_b;
                cnt   <= '0;
                pulse <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/occupancy_counter.sv
// Occupancy / cumulative-entry counter with full flag and reject pulse, fed by debounced buttons.
// All outputs registered one clock after the debounced event.
module occupancy_counter
    import occ_pkg::*;
#(
    parameter int CAPACITY   = 50,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int SUM_MAX    = SUM_MAX_DEF
) (
    input logic               clk,
    input logic               rst,
    occupancy_counter_if.slave bus
);

    localparam logic [NOW_W-1:0] CAP_V  = NOW_W'(CAPACITY);
    localparam logic [SUM_W-1:0] SMAX_V = SUM_W'(SUM_MAX);

    logic             ev_in;
    logic             ev_out;
    logic [NOW_W-1:0] now_q;
    logic [SUM_W-1:0] sum_q;
    logic             full_q;
    logic             reject_q;
    logic [NOW_W-1:0] now_nx;
    logic [SUM_W-1:0] sum_nx;
    logic             entry;
    logic             reject_nx;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_in (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_in),
        .pulse (ev_in)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_out (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_out),
        .pulse (ev_out)
    );

    always_comb begin
        now_nx    = now_q;
        entry     = 1'b0;
        reject_nx = 1'b0;
        case ({ev_in, ev_out})
            2'b10: begin
                if (now_q < CAP_V) begin
                    now_nx = now_q + 1'b1;
                    entry  = 1'b1;
                end else begin
                    reject_nx = 1'b1;
                end
            end
            2'b01: begin
                if (now_q != '0) begin
                    now_nx = now_q - 1'b1;
                end
            end
            2'b11: begin
                // Swap keeps the count; from empty the exit is dropped and the entry stands.
                entry = 1'b1;
                if (now_q == '0) begin
                    now_nx = NOW_W'(1);
                end
            end
            default: begin
                now_nx = now_q;
            end
        endcase
    end

    always_comb begin
        sum_nx = sum_q;
        if (bus.sum_clr) begin
            sum_nx = '0;
        end else if (entry && (sum_q < SMAX_V)) begin
            sum_nx = sum_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q    <= '0;
            sum_q    <= '0;
            full_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            now_q    <= now_nx;
            sum_q    <= sum_nx;
            full_q   <= (now_nx == CAP_V);
            reject_q <= reject_nx;
        end
    end

    assign bus.now_num  = now_q;
    assign bus.sum_num  = sum_q;
    assign bus.full_led = full_q;
    assign bus.reject   = reject_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed scenarios plus random button activity, checked every cycle against a behavioural model.
module tb_occupancy_counter;
    import occ_pkg::*;

    localparam int CAP  = 4;
    localparam int DEB  = 4;
    localparam int SMAX = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    occupancy_counter_if bus ();

    occupancy_counter #(
        .CAPACITY   (CAP),
        .DEB_CYCLES (DEB),
        .SUM_MAX    (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int rej_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a press is accepted when the raw samples seen through a two-stage
    // delay have held one value for DEB consecutive clocks; the event acts one clock later.
    int           m_now, m_sum;
    bit           m_full, m_rej;
    bit           acc_i, acc_o, pend_i, pend_o;
    bit [DEB+1:0] hist_i, hist_o;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_now = 0; m_sum = 0; m_full = 0; m_rej = 0;
            acc_i = 0; acc_o = 0; pend_i = 0; pend_o = 0;
            hist_i = '0; hist_o = '0;
        end else begin
            bit entry;
            entry = 0;
            m_rej = 0;
            if (pend_i && pend_o) begin
                entry = 1;
                if (m_now == 0) m_now = 1;
            end else if (pend_i) begin
                if (m_now < CAP) begin m_now = m_now + 1; entry = 1; end
                else m_rej = 1;
            end else if (pend_o) begin
                if (m_now > 0) m_now = m_now - 1;
            end
            if (bus.sum_clr) m_sum = 0;
            else if (entry && m_sum < SMAX) m_sum = m_sum + 1;
            m_full = (m_now == CAP);

            pend_i = 0;
            if (hist_i[DEB:1] == '1 && !acc_i) begin acc_i = 1; pend_i = 1; end
            else if (hist_i[DEB:1] == '0 && acc_i) acc_i = 0;
            pend_o = 0;
            if (hist_o[DEB:1] == '1 && !acc_o) begin acc_o = 1; pend_o = 1; end
            else if (hist_o[DEB:1] == '0 && acc_o) acc_o = 0;
            hist_i = {hist_i[DEB:0], bus.btn_in};
            hist_o = {hist_o[DEB:0], bus.btn_out};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("now_num", bus.now_num, m_now);
            check("sum_num", bus.sum_num, m_sum);
            check("full_led", bus.full_led, m_full);
            check("reject", bus.reject, m_rej);
            if (bus.reject) rej_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit bi, input bit bo);
        @(negedge clk);
        bus.btn_in  = bi;
        bus.btn_out = bo;
        cyc(DEB + 6);
        bus.btn_in  = 1'b0;
        bus.btn_out = 1'b0;
        cyc(DEB + 4);
    endtask

    // Counts negedges from now until now_num moves; btn_in must already be driven.
    task automatic wait_change(input string name, input int exp);
        logic [NOW_W-1:0] old;
        int n;
        old = bus.now_num;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.now_num != old) break;
        end
        check(name, n, exp);
    endtask

    initial begin
        int rej0;
        int bnd;
        bus.btn_in  = 1'b0;
        bus.btn_out = 1'b0;
        bus.sum_clr = 1'b0;
        cyc(3);
        check("rst_now", bus.now_num, 0);
        check("rst_sum", bus.sum_num, 0);
        check("rst_full", bus.full_led, 0);
        check("rst_reject", bus.reject, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // First press: output moves DEB+3 clocks after the edge.
        @(negedge clk);
        bus.btn_in = 1'b1;
        wait_change("press_latency", DEB + 3);
        cyc(4);
        bus.btn_in = 1'b0;
        cyc(DEB + 4);
        press(1, 0);
        press(1, 0);
        check("basic_now", bus.now_num, 3);
        check("basic_sum", bus.sum_num, 3);
        check("basic_full", bus.full_led, 0);

        // Bounce: toggle every 2 clocks for 20 clocks, then hold.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.btn_in = ~bus.btn_in;
            @(negedge clk);
        end
        bus.btn_in = 1'b1;
        cyc(10);
        bus.btn_in = 1'b0;
        cyc(DEB + 4);
        check("bounce_now", bus.now_num, 4);
        check("full_set", bus.full_led, 1);

        rej0 = rej_seen;
        press(1, 0);
        check("reject_once", rej_seen - rej0, 1);
        check("full_hold_now", bus.now_num, 4);

        press(1, 1);
        check("swap_full_now", bus.now_num, 4);
        check("swap_full_sum", bus.sum_num, 5);
        check("swap_full_norej", rej_seen - rej0, 1);

        press(0, 1);
        check("exit_now", bus.now_num, 3);
        check("exit_full", bus.full_led, 0);
        repeat (4) press(0, 1);
        check("underflow_now", bus.now_num, 0);

        press(1, 1);
        check("swap_empty_now", bus.now_num, 1);
        check("swap_empty_sum", bus.sum_num, 6);

        repeat (3) press(1, 0);
        check("sat_sum", bus.sum_num, SMAX);
        check("sat_now", bus.now_num, 4);

        // Clear strobe lands on the same clock as an entry event.
        press(0, 1);
        @(negedge clk);
        bus.btn_in = 1'b1;
        bnd = 0;
        while (!pend_i && bnd < 40) begin @(negedge clk); bnd++; end
        check("clr_wait", (bnd < 40), 1);
        bus.sum_clr = 1'b1;
        @(negedge clk);
        bus.sum_clr = 1'b0;
        check("clr_sum", bus.sum_num, 0);
        check("clr_now", bus.now_num, 4);
        bus.btn_in = 1'b0;
        cyc(DEB + 4);

        // Async reset while an entry is mid-debounce.
        press(0, 1);
        press(0, 1);
        check("pre_rst_now", bus.now_num, 2);
        @(negedge clk);
        bus.btn_in = 1'b1;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check("arst_now", bus.now_num, 0);
        check("arst_sum", bus.sum_num, 0);
        check("arst_full", bus.full_led, 0);
        cyc(2);
        rst = 1'b0;
        wait_change("post_rst_latency", DEB + 3);
        check("post_rst_sum", bus.sum_num, 1);
        bus.btn_in = 1'b0;
        cyc(DEB + 4);

        // Random activity with bounces, overlaps and clears.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) bus.btn_in  = ~bus.btn_in;
            if ($urandom_range(0, 11) == 0) bus.btn_out = ~bus.btn_out;
            bus.sum_clr = ($urandom_range(0, 39) == 0);
        end
        bus.sum_clr = 1'b0;
        cyc(DEB + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
